// File: rtl/wr1_port_arbiter.sv
// rtl/wr1_port_arbiter.sv - two-requester (ALU/LSU) round-robin arbiter onto the wide register-file write port
module wr1_port_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_wr_valid,
    output logic         alu_wr_ready,
    input  logic [9:0]   alu_wr_addr,
    input  logic [3:0]   alu_wr_en,
    input  logic [127:0] alu_wr_data,
    input  logic         lsu_wr_valid,
    output logic         lsu_wr_ready,
    input  logic [9:0]   lsu_wr_addr,
    input  logic [3:0]   lsu_wr_en,
    input  logic [127:0] lsu_wr_data,
    output logic [9:0]   wr1_addr,
    output logic [3:0]   wr1_en,
    output logic [127:0] wr1_data,
    output logic         bad_en,
    output logic         idle
);
    // Pointers are single-bit, so the queue depth is fixed at two entries.
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef logic [141:0] entry_t;

    entry_t     alu_mem [2];
    entry_t     lsu_mem [2];
    logic       alu_wp, alu_rp, lsu_wp, lsu_rp;
    logic [1:0] alu_cnt, lsu_cnt;
    logic       last_lsu;
    logic       alu_acc, lsu_acc, alu_push, lsu_push, alu_pop, lsu_pop, any_bad;
    entry_t     head;

    function automatic logic en_legal(input logic [3:0] en);
        return (en == 4'b0001) || (en == 4'b0011) || (en == 4'b1111);
    endfunction

    assign alu_wr_ready = !rst && (alu_cnt < DEPTH);
    assign lsu_wr_ready = !rst && (lsu_cnt < DEPTH);

    assign alu_acc  = alu_wr_valid && alu_wr_ready;
    assign lsu_acc  = lsu_wr_valid && lsu_wr_ready;
    // Enable 0000 is accepted but never queued; it simply vanishes.
    assign alu_push = alu_acc && en_legal(alu_wr_en);
    assign lsu_push = lsu_acc && en_legal(lsu_wr_en);
    assign any_bad  = (alu_acc && !en_legal(alu_wr_en) && (alu_wr_en != 4'b0000)) ||
                      (lsu_acc && !en_legal(lsu_wr_en) && (lsu_wr_en != 4'b0000));

    // ALU wins when alone or when LSU had the previous grant.
    assign alu_pop = (alu_cnt != 2'd0) && ((lsu_cnt == 2'd0) || last_lsu);
    assign lsu_pop = (lsu_cnt != 2'd0) && !alu_pop;
    assign head    = alu_pop ? alu_mem[alu_rp] : lsu_mem[lsu_rp];

    assign idle = (alu_cnt == 2'd0) && (lsu_cnt == 2'd0) && (wr1_en == 4'b0000);

    always_ff @(posedge clk) begin
        if (alu_push) alu_mem[alu_wp] <= {alu_wr_addr, alu_wr_en, alu_wr_data};
        if (lsu_push) lsu_mem[lsu_wp] <= {lsu_wr_addr, lsu_wr_en, lsu_wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wp   <= 1'b0;
            alu_rp   <= 1'b0;
            alu_cnt  <= 2'd0;
            lsu_wp   <= 1'b0;
            lsu_rp   <= 1'b0;
            lsu_cnt  <= 2'd0;
            last_lsu <= 1'b1;
            wr1_addr <= 10'd0;
            wr1_en   <= 4'b0000;
            wr1_data <= 128'd0;
            bad_en   <= 1'b0;
        end else begin
            if (alu_push) alu_wp <= ~alu_wp;
            if (alu_pop)  alu_rp <= ~alu_rp;
            if (lsu_push) lsu_wp <= ~lsu_wp;
            if (lsu_pop)  lsu_rp <= ~lsu_rp;
            alu_cnt <= alu_cnt + 2'(alu_push) - 2'(alu_pop);
            lsu_cnt <= lsu_cnt + 2'(lsu_push) - 2'(lsu_pop);
            bad_en  <= any_bad;
            if (alu_pop || lsu_pop) begin
                last_lsu <= lsu_pop;
                wr1_addr <= head[141:132];
                wr1_en   <= head[131:128];
                wr1_data <= head[127:0];
            end else begin
                wr1_en <= 4'b0000;
            end
        end
    end
endmodule

// File: tb/tb_wr1_port_arbiter.sv
// tb/tb_wr1_port_arbiter.sv - directed self-checking bench for wr1_port_arbiter
module tb_wr1_port_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         alu_wr_valid, alu_wr_ready;
    logic [9:0]   alu_wr_addr;
    logic [3:0]   alu_wr_en;
    logic [127:0] alu_wr_data;
    logic         lsu_wr_valid, lsu_wr_ready;
    logic [9:0]   lsu_wr_addr;
    logic [3:0]   lsu_wr_en;
    logic [127:0] lsu_wr_data;
    logic [9:0]   wr1_addr;
    logic [3:0]   wr1_en;
    logic [127:0] wr1_data;
    logic         bad_en, idle;

    int tests_run = 0;
    int tests_failed = 0;

    logic [137:0] alu_q[$];
    logic [137:0] lsu_q[$];

    wr1_port_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_wr_valid(alu_wr_valid), .alu_wr_ready(alu_wr_ready),
        .alu_wr_addr(alu_wr_addr), .alu_wr_en(alu_wr_en), .alu_wr_data(alu_wr_data),
        .lsu_wr_valid(lsu_wr_valid), .lsu_wr_ready(lsu_wr_ready),
        .lsu_wr_addr(lsu_wr_addr), .lsu_wr_en(lsu_wr_en), .lsu_wr_data(lsu_wr_data),
        .wr1_addr(wr1_addr), .wr1_en(wr1_en), .wr1_data(wr1_data),
        .bad_en(bad_en), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alu_wr_valid = 1'b0; alu_wr_addr = '0; alu_wr_en = '0; alu_wr_data = '0;
        lsu_wr_valid = 1'b0; lsu_wr_addr = '0; lsu_wr_en = '0; lsu_wr_data = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        alu_wr_valid = 1'b0; lsu_wr_valid = 1'b0;
        alu_wr_addr = '0; alu_wr_en = '0; alu_wr_data = '0;
        lsu_wr_addr = '0; lsu_wr_en = '0; lsu_wr_data = '0;
        rst = 1'b1;
        step();
        tests_run++;
        if (alu_wr_ready !== 1'b0 || lsu_wr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_low: alu=%b lsu=%b expected 0 0", alu_wr_ready, lsu_wr_ready);
        end
        tests_run++;
        if (wr1_en !== 4'b0000 || wr1_addr !== 10'd0 || wr1_data !== 128'd0 || bad_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: en=%h addr=%h data=%h bad=%b expected all 0", wr1_en, wr1_addr, wr1_data, bad_en);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (alu_wr_ready !== 1'b1 || lsu_wr_ready !== 1'b1 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: alu_rdy=%b lsu_rdy=%b idle=%b expected 1 1 1", alu_wr_ready, lsu_wr_ready, idle);
        end
    endtask

    task automatic test_single();
        do_reset();
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h005; alu_wr_en = 4'b0001; alu_wr_data = 128'hA5;
        step();
        alu_wr_valid = 1'b0;
        tests_run++;
        if (wr1_en !== 4'b0000 || idle !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency1: en=%b idle=%b expected 0000 0", wr1_en, idle);
        end
        step();
        tests_run++;
        if (wr1_en !== 4'b0001 || wr1_addr !== 10'h005 || wr1_data[31:0] !== 32'hA5) begin
            tests_failed++;
            $display("FAIL single_write: en=%b addr=%h data=%h expected 0001 005 a5", wr1_en, wr1_addr, wr1_data[31:0]);
        end
        step();
        tests_run++;
        if (wr1_en !== 4'b0000 || wr1_addr !== 10'h005 || wr1_data[31:0] !== 32'hA5 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_one_cycle: en=%b addr=%h data=%h idle=%b expected 0000 005 a5 1", wr1_en, wr1_addr, wr1_data[31:0], idle);
        end
    endtask

    task automatic test_tie();
        logic [9:0] exp_addr [4];
        logic [3:0] exp_en [4];
        exp_addr[0] = 10'h010; exp_en[0] = 4'b0001;
        exp_addr[1] = 10'h3FF; exp_en[1] = 4'b1111;
        exp_addr[2] = 10'h011; exp_en[2] = 4'b0001;
        exp_addr[3] = 10'h3FE; exp_en[3] = 4'b1111;
        do_reset();
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h010; alu_wr_en = 4'b0001; alu_wr_data = 128'h1;
        lsu_wr_valid = 1'b1; lsu_wr_addr = 10'h3FF; lsu_wr_en = 4'b1111; lsu_wr_data = 128'h2;
        step();
        alu_wr_addr = 10'h011; lsu_wr_addr = 10'h3FE;
        step();
        alu_wr_valid = 1'b0; lsu_wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (wr1_en !== exp_en[i] || wr1_addr !== exp_addr[i]) begin
                tests_failed++;
                $display("FAIL tie_order[%0d]: en=%b addr=%h expected %b %h", i, wr1_en, wr1_addr, exp_en[i], exp_addr[i]);
            end
            step();
        end
        tests_run++;
        if (wr1_en !== 4'b0000 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL tie_drained: en=%b idle=%b expected 0000 1", wr1_en, idle);
        end
    endtask

    task automatic test_back_to_back();
        int a_n = 0;
        int l_n = 0;
        int prev = -1;
        int cur;
        bit saw_stall = 0;
        logic a_acc, l_acc;
        logic [137:0] exp;
        alu_q.delete(); lsu_q.delete();
        do_reset();
        alu_wr_valid = 1'b1; alu_wr_en = 4'b0001; alu_wr_addr = 10'h100; alu_wr_data = 128'hA000_0000;
        lsu_wr_valid = 1'b1; lsu_wr_en = 4'b1111; lsu_wr_addr = 10'h200; lsu_wr_data = 128'hB000_0000;
        for (int k = 1; k <= 27; k++) begin
            a_acc = alu_wr_valid && alu_wr_ready;
            l_acc = lsu_wr_valid && lsu_wr_ready;
            step();
            if (a_acc) begin
                alu_q.push_back({alu_wr_addr, alu_wr_data});
                a_n++;
                alu_wr_addr = 10'(10'h100 + a_n);
                alu_wr_data = {96'd0, 32'hA000_0000 | 32'(a_n)};
            end
            if (l_acc) begin
                lsu_q.push_back({lsu_wr_addr, lsu_wr_data});
                l_n++;
                lsu_wr_addr = 10'(10'h200 + l_n);
                lsu_wr_data = {96'd0, 32'hB000_0000 | 32'(l_n)};
            end
            if (lsu_wr_valid && !lsu_wr_ready) saw_stall = 1;
            if (wr1_en !== 4'b0000) begin
                cur = (wr1_addr[9:8] == 2'b01) ? 0 : 1;
                tests_run++;
                if ((cur == 0 && alu_q.size() == 0) || (cur == 1 && lsu_q.size() == 0)) begin
                    tests_failed++;
                    $display("FAIL b2b_unexpected_write: addr=%h with empty expected queue", wr1_addr);
                end else begin
                    exp = (cur == 0) ? alu_q.pop_front() : lsu_q.pop_front();
                    if (wr1_addr !== exp[137:128] || wr1_data !== exp[127:0] ||
                        wr1_en !== ((cur == 0) ? 4'b0001 : 4'b1111)) begin
                        tests_failed++;
                        $display("FAIL b2b_data: addr=%h data=%h en=%b expected addr=%h data=%h", wr1_addr, wr1_data[31:0], wr1_en, exp[137:128], exp[31:0]);
                    end
                end
                if (k >= 3 && k <= 20) begin
                    tests_run++;
                    if (cur == prev) begin
                        tests_failed++;
                        $display("FAIL b2b_alternate: requester %0d granted twice in a row at cycle %0d", cur, k);
                    end
                end
                prev = cur;
            end
            if (k >= 2 && k <= 20) begin
                tests_run++;
                if (wr1_en === 4'b0000) begin
                    tests_failed++;
                    $display("FAIL b2b_throughput: cycle %0d en=%b expected nonzero", k, wr1_en);
                end
            end
            if (k == 20) begin
                alu_wr_valid = 1'b0;
                lsu_wr_valid = 1'b0;
            end
        end
        tests_run++;
        if (!saw_stall || alu_q.size() != 0 || lsu_q.size() != 0 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_drain: stall_seen=%0d alu_left=%0d lsu_left=%0d idle=%b expected 1 0 0 1", saw_stall, alu_q.size(), lsu_q.size(), idle);
        end
    endtask

    task automatic test_bad_en();
        do_reset();
        lsu_wr_valid = 1'b1; lsu_wr_addr = 10'h020; lsu_wr_en = 4'b0010; lsu_wr_data = 128'h33;
        step();
        lsu_wr_valid = 1'b0;
        tests_run++;
        if (bad_en !== 1'b1 || wr1_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bad_en_pulse: bad=%b en=%b expected 1 0000", bad_en, wr1_en);
        end
        step();
        tests_run++;
        if (bad_en !== 1'b0 || wr1_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bad_en_single: bad=%b en=%b expected 0 0000", bad_en, wr1_en);
        end
        step();
        tests_run++;
        if (wr1_en !== 4'b0000 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_en_no_write: en=%b idle=%b expected 0000 1", wr1_en, idle);
        end
        lsu_wr_valid = 1'b1; lsu_wr_en = 4'b0000;
        step();
        lsu_wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (bad_en !== 1'b0 || wr1_en !== 4'b0000 || idle !== 1'b1) begin
                tests_failed++;
                $display("FAIL zero_en_silent[%0d]: bad=%b en=%b idle=%b expected 0 0000 1", i, bad_en, wr1_en, idle);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h040; alu_wr_en = 4'b0011; alu_wr_data = 128'h40;
        lsu_wr_valid = 1'b1; lsu_wr_addr = 10'h050; lsu_wr_en = 4'b1111; lsu_wr_data = 128'h50;
        step();
        alu_wr_addr = 10'h041; lsu_wr_addr = 10'h051;
        step();
        alu_wr_valid = 1'b0; lsu_wr_valid = 1'b0;
        rst = 1'b1;
        step();
        tests_run++;
        if (wr1_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_no_write: en=%b expected 0000", wr1_en);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (alu_wr_ready !== 1'b1 || lsu_wr_ready !== 1'b1 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_state: alu_rdy=%b lsu_rdy=%b idle=%b expected 1 1 1", alu_wr_ready, lsu_wr_ready, idle);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (wr1_en !== 4'b0000) begin
                tests_failed++;
                $display("FAIL midreset_stale[%0d]: en=%b addr=%h expected 0000", i, wr1_en, wr1_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_bad_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/wr1_port_arbiter.md
WR1_PORT_ARBITER -- requirements
Module: wr1_port_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, entries per requester queue (fixed at 2 in this revision).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports alu_wr_valid/alu_wr_ready  input/output  1/1  ALU requester handshake.
REQ-005 SHALL have ports alu_wr_addr  input  10  and  alu_wr_en  input  4  ALU register address and enable code.
REQ-006 SHALL have port alu_wr_data  input  128  ALU write data, word 0 in bits [31:0].
REQ-007 SHALL have ports lsu_wr_valid/lsu_wr_ready  input/output  1/1  LSU requester handshake.
REQ-008 SHALL have ports lsu_wr_addr  input  10,  lsu_wr_en  input  4,  lsu_wr_data  input  128  LSU request fields.
REQ-009 SHALL have ports wr1_addr  output  10,  wr1_en  output  4,  wr1_data  output  128  register-file wide write port.
REQ-010 SHALL have ports bad_en  output  1  (illegal-enable pulse) and idle  output  1  (both queues empty, no write this cycle).

Function
REQ-011 SHALL accept a request on a rising edge where valid and ready are both high; the request is then pushed into that requester's FIFO.
REQ-012 SHALL drive each ready high iff that FIFO holds fewer than 2 entries, from registered count only; no combinational valid->ready path.
REQ-013 SHALL keep accepted requests in order per requester; no reordering within a requester.
REQ-014 SHALL treat only wr_en codes 0000, 0001, 0011, 1111 as legal; 0000 is accepted and discarded silently.
REQ-015 SHALL accept any other wr_en code, discard it, and pulse bad_en high for exactly one cycle (the cycle after acceptance).
REQ-016 SHALL select at most one FIFO head per cycle; when only one FIFO is non-empty, grant it.
REQ-017 SHALL use round-robin when both are non-empty: grant the requester not granted last; last-grant pointer updates only on grant.
REQ-018 SHALL register the granted head onto wr1_addr/wr1_en/wr1_data the cycle after the grant, for exactly one cycle; wr1_en=0000 in all other cycles.
REQ-019 SHALL pass wr1_addr unmodified (unaligned addresses and wrap past 1023 are handled downstream).
REQ-020 SHALL give minimum latency of 2 cycles: accepted at edge N, popped at edge N+1, wr1_en non-zero during cycle after edge N+1.
REQ-021 SHALL support push and pop on the same edge for the same FIFO; count unchanged, order preserved.
REQ-022 SHALL hold wr1_addr/wr1_data stable (last value) when wr1_en=0000.
REQ-023 SHALL drive idle high iff both counts are 0 and wr1_en is 0000.
REQ-024 SHALL sustain one write per cycle when both queues are continuously fed (full throughput, alternating grants).

Reset
REQ-025 SHALL on rst clear both FIFO counts and pointers, set wr1_en=0000, wr1_addr=0, wr1_data=0, bad_en=0, and set last-grant to LSU so ALU wins first tie.
REQ-026 SHALL drive alu_wr_ready=lsu_wr_ready=0 during the rst cycle and 1 the cycle after; idle=1 after reset.
REQ-027 SHALL drop all queued and in-flight requests on rst asserted mid-operation; no write issues in the cycle following the reset edge.

Verification
REQ-028 Single ALU request addr=0x005 en=0001 data=0xA5 -> wr1_en=0001, wr1_addr=0x005, wr1_data[31:0]=0xA5 two cycles after acceptance, one cycle only.
REQ-029 ALU and LSU valid together from reset (ALU addr 0x010, LSU addr 0x3FF en=1111) -> ALU write first, LSU next cycle; repeat pair -> grants alternate ALU/LSU.
REQ-030 Hold LSU valid with wr1 writes stalled by constant ALU traffic -> lsu_wr_ready low when 2 entries queued, no loss, writes emerge in order.
REQ-031 LSU request en=0010 -> no wr1 write, bad_en one-cycle pulse; en=0000 -> no write, no bad_en.
REQ-032 Three queued entries then rst -> next cycle wr1_en=0000, both readies high, idle=1, no stale write ever appears.
